bus_share_arbiter: RTL and testbench
====================================

BUS_SHARE_ARBITER -- requirements
Module: bus_share_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4, range 1-7: maximum consecutive beats one requester may hold the shared 4-bit path while the other requester waits.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; rst=0 forces reset state immediately, independent of clk.
REQ-004 reqA  input  1  requester A wants the path; held high for as long as A has beats to send.
REQ-005 reqB  input  1  requester B wants the path; same rules as reqA.
REQ-006 dataA  input  4  requester A beat data.
REQ-007 dataB  input  4  requester B beat data.
REQ-008 grantA  output  1  registered; A owns the path this cycle.
REQ-009 grantB  output  1  registered; B owns the path this cycle.
REQ-010 select  output  1  registered mux select for the shared 2:1 path; 0 routes dataA, 1 routes dataB.
REQ-011 Y  output  4  registered transferred beat.
REQ-012 valid  output  1  registered; Y holds a new beat this cycle.

Function
REQ-013 FSM states: IDLE, GRANT_A, GRANT_B; grantA=1 exactly in GRANT_A, grantB=1 exactly in GRANT_B, never both.
REQ-014 select=1 exactly in GRANT_B, 0 in IDLE and GRANT_A.
REQ-015 Internal lastServed bit records the most recently granted requester; burst counter is 3 bits.
REQ-016 IDLE: reqA only -> GRANT_A; reqB only -> GRANT_B; both -> requester not equal to lastServed; neither -> stay IDLE.
REQ-017 Grant latency: grant asserts on the first rising edge at which the request is sampled high in IDLE (one cycle).
REQ-018 Beat: a cycle in GRANT_A with reqA=1 (GRANT_B with reqB=1); at the next edge Y <= routed data, valid <= 1, counter increments.
REQ-019 Any cycle that is not a beat drives valid <= 0 at the next edge; Y holds its previous value.
REQ-020 Release: in GRANT_A with reqA=0 -> GRANT_B if reqB=1, else IDLE; counter <= 0; no beat; symmetric for GRANT_B.
REQ-021 Burst expiry: a beat that makes the count reach MAX_BURST while the other request is high switches to the other GRANT state at the same edge; counter <= 0.
REQ-022 Burst expiry with the other request low: remain in the current state; counter <= 0; no idle cycle inserted.
REQ-023 lastServed updates on every entry into GRANT_A or GRANT_B.
REQ-024 MAX_BURST=1: strict alternation when both requests stay high.
REQ-025 dataA/dataB are sampled only on beat cycles; changes at other times do not affect Y.

Reset
REQ-026 On rst=0: state IDLE, grantA=0, grantB=0, select=0, Y=4'b0000, valid=0, counter=0, lastServed=B (A wins the first tie).
REQ-027 Reset asserted mid-burst aborts the burst immediately; no beat completes; after release, arbitration restarts from IDLE with the tie rule of REQ-026.
REQ-028 Deasserting rst has no output effect until the first rising edge after release.

Verification
REQ-029 Reset then reqA=reqB=1 held, dataA=4'h3, dataB=4'hC, MAX_BURST=4 -> grantA cycle 1; valid with Y=3 for four cycles; grantB/select=1 the cycle after the 4th beat; then four Y=C beats; pattern repeats.
REQ-030 reqA=1 alone for 10 cycles, dataA counting 0..9 -> grantA stays high; no idle gaps; Y=0..9 each one cycle after its beat; valid continuous.
REQ-031 GRANT_A after 2 beats, reqA drops with reqB=1 -> next edge grantB=1, grantA=0, valid=0 for that cycle, counter 0; B beats follow.
REQ-032 MAX_BURST=1, both requests held -> grants alternate A,B,A,B every cycle; Y alternates dataA/dataB values.
REQ-033 rst=0 pulsed mid-cycle during a B burst with Y=4'hC -> outputs reset immediately without a clock edge: Y=0, valid=0, grants 0, select=0; after release with both requesting, A granted first.
REQ-034 Neither request from reset for 5 cycles -> IDLE held; all outputs stay at reset values.

Source files
------------

// File: rtl/bus_share_arbiter_if.sv
// Bundle of the two requester handshakes and the shared 4-bit output path.
// The master side belongs to the requesters/consumer.
// The slave side belongs to the arbiter that owns the path.
interface bus_share_arbiter_if;

   logic       reqA;
   logic       reqB;
   logic [3:0] dataA;
   logic [3:0] dataB;
   logic       grantA;
   logic       grantB;
   logic       select;
   logic [3:0] Y;
   logic       valid;

   modport master (
      output reqA,
      output reqB,
      output dataA,
      output dataB,
      input  grantA,
      input  grantB,
      input  select,
      input  Y,
      input  valid
   );

   modport slave (
      input  reqA,
      input  reqB,
      input  dataA,
      input  dataB,
      output grantA,
      output grantB,
      output select,
      output Y,
      output valid
   );

endinterface

// File: rtl/bus_share_arbiter.sv
// Two-requester arbiter for a shared 4-bit path.
// A requester that holds the path is limited to MAX_BURST consecutive beats
// while the other requester waits. Ties out of IDLE go to whichever requester
// was not served most recently.
// All outputs come straight from flops.
module bus_share_arbiter #(
   parameter int MAX_BURST = 4
) (
   input logic                  clk,
   input logic                  rst,
   bus_share_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GRANT_A = 2'b01,
      GRANT_B = 2'b10
   } state_t;

   localparam logic       SERVED_A  = 1'b0;
   localparam logic       SERVED_B  = 1'b1;
   localparam logic [2:0] BURST_MAX = 3'(MAX_BURST);

   state_t     state;
   state_t     stateNext;
   logic [2:0] count;
   logic [2:0] countNext;
   logic [2:0] countInc;
   logic       lastServed;
   logic       lastNext;
   logic [3:0] yReg;
   logic [3:0] yNext;
   logic       validReg;
   logic       validNext;
   logic       grantAReg;
   logic       grantBReg;
   logic       selectReg;

   assign countInc = count + 3'd1;

   // Next-state, burst counter, fairness bit and beat capture for every state.
   // A cycle that is not a beat leaves Y alone and drops valid.
   always_comb begin
      stateNext = state;
      countNext = count;
      lastNext  = lastServed;
      yNext     = yReg;
      validNext = 1'b0;
      unique case (state)
         IDLE: begin
            countNext = 3'd0;
            if (bus.reqA && (!bus.reqB || lastServed == SERVED_B)) begin
               stateNext = GRANT_A;
               lastNext  = SERVED_A;
            end else if (bus.reqB) begin
               stateNext = GRANT_B;
               lastNext  = SERVED_B;
            end
         end
         GRANT_A: begin
            if (bus.reqA) begin
               yNext     = bus.dataA;
               validNext = 1'b1;
               if (countInc == BURST_MAX) begin
                  countNext = 3'd0;
                  if (bus.reqB) begin
                     stateNext = GRANT_B;
                     lastNext  = SERVED_B;
                  end
               end else begin
                  countNext = countInc;
               end
            end else begin
               countNext = 3'd0;
               if (bus.reqB) begin
                  stateNext = GRANT_B;
                  lastNext  = SERVED_B;
               end else begin
                  stateNext = IDLE;
               end
            end
         end
         GRANT_B: begin
            if (bus.reqB) begin
               yNext     = bus.dataB;
               validNext = 1'b1;
               if (countInc == BURST_MAX) begin
                  countNext = 3'd0;
                  if (bus.reqA) begin
                     stateNext = GRANT_A;
                     lastNext  = SERVED_A;
                  end
               end else begin
                  countNext = countInc;
               end
            end else begin
               countNext = 3'd0;
               if (bus.reqA) begin
                  stateNext = GRANT_A;
                  lastNext  = SERVED_A;
               end else begin
                  stateNext = IDLE;
               end
            end
         end
         default: begin
            stateNext = IDLE;
            countNext = 3'd0;
         end
      endcase
   end

   // State, counter and fairness bit.
   // Reset leaves lastServed pointing at B, so A wins the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         count      <= 3'd0;
         lastServed <= SERVED_B;
      end else begin
         state      <= stateNext;
         count      <= countNext;
         lastServed <= lastNext;
      end
   end

   // Output flops.
   // Grants and select are decoded from the next state so they line up
   // with the state register without any combinational decode on the pins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grantAReg <= 1'b0;
         grantBReg <= 1'b0;
         selectReg <= 1'b0;
         yReg      <= 4'b0000;
         validReg  <= 1'b0;
      end else begin
         grantAReg <= (stateNext == GRANT_A);
         grantBReg <= (stateNext == GRANT_B);
         selectReg <= (stateNext == GRANT_B);
         yReg      <= yNext;
         validReg  <= validNext;
      end
   end

   assign bus.grantA = grantAReg;
   assign bus.grantB = grantBReg;
   assign bus.select = selectReg;
   assign bus.Y      = yReg;
   assign bus.valid  = validReg;

endmodule

// File: tb/tb_bus_share_arbiter.sv
// Directed bench for bus_share_arbiter.
// One instance uses MAX_BURST=4 and a second uses MAX_BURST=1. Both share
// the clock, reset and request/data stimulus.
// Outputs are packed as {grantA, grantB, select, valid, Y}.
module tb_bus_share_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       reqA;
   logic       reqB;
   logic [3:0] dataA;
   logic [3:0] dataB;

   int compareCount = 0;
   int failCount    = 0;

   bus_share_arbiter_if bus4 ();
   bus_share_arbiter_if bus1 ();

   assign bus4.reqA  = reqA;
   assign bus4.reqB  = reqB;
   assign bus4.dataA = dataA;
   assign bus4.dataB = dataB;
   assign bus1.reqA  = reqA;
   assign bus1.reqB  = reqB;
   assign bus1.dataA = dataA;
   assign bus1.dataB = dataB;

   bus_share_arbiter #(.MAX_BURST(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
   bus_share_arbiter #(.MAX_BURST(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   function automatic logic [7:0] pack(input logic ga, input logic gb, input logic sel,
                                       input logic v, input logic [3:0] y);
      return {ga, gb, sel, v, y};
   endfunction

   function automatic logic [7:0] out4();
      return {bus4.grantA, bus4.grantB, bus4.select, bus4.valid, bus4.Y};
   endfunction

   function automatic logic [7:0] out1();
      return {bus1.grantA, bus1.grantB, bus1.select, bus1.valid, bus1.Y};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic a, input logic b,
                                input logic [3:0] da, input logic [3:0] db);
      reqA  = a;
      reqB  = b;
      dataA = da;
      dataB = db;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compareCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Directed sequence.
   initial begin
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      checkOutput("reset_async4", out4(), pack(0, 0, 0, 0, 4'h0));
      checkOutput("reset_async1", out1(), pack(0, 0, 0, 0, 4'h0));
      tick();
      checkOutput("reset_held", out4(), pack(0, 0, 0, 0, 4'h0));
      rst = 1'b1;
      #1;
      checkOutput("release_noeffect", out4(), pack(0, 0, 0, 0, 4'h0));

      // No requests: IDLE holds and outputs keep reset values.
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput($sformatf("idle_%0d", i), out4(), pack(0, 0, 0, 0, 4'h0));
      end

      // Both requesting, MAX_BURST=4: A first, four A beats, then B.
      applyStimulus(1'b1, 1'b1, 4'h3, 4'hC);
      tick();
      checkOutput("both_grantA", out4(), pack(1, 0, 0, 0, 4'h0));
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("both_beatA_%0d", i), out4(), pack(1, 0, 0, 1, 4'h3));
      end
      tick();
      checkOutput("both_switchB", out4(), pack(0, 1, 1, 1, 4'h3));
      tick();
      checkOutput("both_beatB_0", out4(), pack(0, 1, 1, 1, 4'hC));
      tick();
      checkOutput("both_beatB_1", out4(), pack(0, 1, 1, 1, 4'hC));

      // Asynchronous reset mid-cycle during the B burst.
      #2 rst = 1'b0;
      #1;
      checkOutput("midburst_reset4", out4(), pack(0, 0, 0, 0, 4'h0));
      checkOutput("midburst_reset1", out1(), pack(0, 0, 0, 0, 4'h0));
      tick();
      checkOutput("midburst_held", out4(), pack(0, 0, 0, 0, 4'h0));
      rst = 1'b1;
      #1;
      checkOutput("midburst_release", out4(), pack(0, 0, 0, 0, 4'h0));
      tick();
      checkOutput("restart_grantA", out4(), pack(1, 0, 0, 0, 4'h0));
      for (int i = 0; i < 4; i++) tick();
      checkOutput("restart_switchB", out4(), pack(0, 1, 1, 1, 4'h3));
      for (int i = 0; i < 4; i++) tick();
      checkOutput("repeat_switchA", out4(), pack(1, 0, 0, 1, 4'hC));
      tick();
      checkOutput("repeat_beatA", out4(), pack(1, 0, 0, 1, 4'h3));

      // Reset, then A alone streams 0..9 with no gaps past the burst limit.
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
      tick();
      checkOutput("solo_grantA", out4(), pack(1, 0, 0, 0, 4'h0));
      for (int i = 0; i < 10; i++) begin
         dataA = 4'(i);
         tick();
         checkOutput($sformatf("solo_beat_%0d", i), out4(), pack(1, 0, 0, 1, 4'(i)));
      end
      reqA = 1'b0;
      tick();
      checkOutput("solo_release", out4(), pack(0, 0, 0, 0, 4'h9));
      dataA = 4'hF;
      tick();
      checkOutput("idle_data_ignored", out4(), pack(0, 0, 0, 0, 4'h9));

      // Tie after A was last served goes to B.
      applyStimulus(1'b1, 1'b1, 4'hF, 4'h7);
      tick();
      checkOutput("tie_grantB", out4(), pack(0, 1, 1, 0, 4'h9));
      applyStimulus(1'b0, 1'b0, 4'hF, 4'h7);
      tick();
      checkOutput("tie_release", out4(), pack(0, 0, 0, 0, 4'h9));

      // A gets two beats, drops out with B waiting; B then gets a full burst.
      applyStimulus(1'b1, 1'b0, 4'h5, 4'hA);
      tick();
      checkOutput("rel_grantA", out4(), pack(1, 0, 0, 0, 4'h9));
      tick();
      checkOutput("rel_beatA_0", out4(), pack(1, 0, 0, 1, 4'h5));
      tick();
      checkOutput("rel_beatA_1", out4(), pack(1, 0, 0, 1, 4'h5));
      applyStimulus(1'b0, 1'b1, 4'h5, 4'hA);
      tick();
      checkOutput("rel_toB", out4(), pack(0, 1, 1, 0, 4'h5));
      reqA = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("rel_beatB_%0d", i), out4(), pack(0, 1, 1, 1, 4'hA));
      end
      tick();
      checkOutput("rel_expire_toA", out4(), pack(1, 0, 0, 1, 4'hA));

      // MAX_BURST=1 strict alternation.
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      applyStimulus(1'b1, 1'b1, 4'h6, 4'h9);
      tick();
      checkOutput("alt_grantA", out1(), pack(1, 0, 0, 0, 4'h0));
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("alt_B_%0d", i), out1(), pack(0, 1, 1, 1, 4'h6));
         tick();
         checkOutput($sformatf("alt_A_%0d", i), out1(), pack(1, 0, 0, 1, 4'h9));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
